// File: rtl/bp_pkg.sv
// Shared constants, entry layout and PC field helpers for the branch predictor.
package bp_pkg;

  // 2-bit saturating counter states; bit 1 set means predict taken.
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam int unsigned BP_ADDR_W  = 32;
  localparam int unsigned BP_ENTRIES = 16;
  localparam int unsigned BP_IDX_W   = $clog2(BP_ENTRIES);
  localparam int unsigned BP_TAG_W   = BP_ADDR_W - BP_IDX_W - 2;

  // Entry layout at the default geometry.
  typedef struct packed {
    logic                 valid;
    logic [BP_TAG_W-1:0]  tag;
    logic [1:0]           ctr;
    logic [BP_ADDR_W-1:0] target;
  } bp_entry_t;

  // Width-generic field extraction; callers keep the low bits they need.
  function automatic logic [63:0] bp_index(input logic [63:0] pc, input int unsigned idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return (pc >> 2) & mask;
  endfunction

  function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int unsigned idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_ctr.sv
// Next-state function of the 2-bit saturating direction counter.
module bp_sat_ctr
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch history table with target buffer; lookup in IF, training in ID.
// Define BP_STATS_EN to add saturating branch / mispredict counters as outputs.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] if_pc_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_i,
  output logic              mispredict_o
`ifdef BP_STATS_EN
  ,
  output logic [31:0]       stat_branches_o,
  output logic [31:0]       stat_mispredicts_o
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  // Table storage, one field per array
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [ADDR_W-1:0]  target_d [ENTRIES];

  logic [63:0]      if_idx_full, if_tag_full, upd_idx_full, upd_tag_full;
  logic [IDX_W-1:0] if_idx, upd_idx;
  logic [TAG_W-1:0] if_tag, upd_tag;
  logic             if_hit, upd_hit, upd_accept;
  logic [1:0]       upd_ctr_next;
  logic             unused_addr_hi;

  assign if_idx_full  = bp_index(64'(if_pc_i), IDX_W);
  assign if_tag_full  = bp_tag(64'(if_pc_i), IDX_W);
  assign upd_idx_full = bp_index(64'(upd_pc_i), IDX_W);
  assign upd_tag_full = bp_tag(64'(upd_pc_i), IDX_W);

  assign if_idx  = if_idx_full[IDX_W-1:0];
  assign if_tag  = if_tag_full[TAG_W-1:0];
  assign upd_idx = upd_idx_full[IDX_W-1:0];
  assign upd_tag = upd_tag_full[TAG_W-1:0];

  assign unused_addr_hi = ^{if_idx_full[63:IDX_W], if_tag_full[63:TAG_W],
                            upd_idx_full[63:IDX_W], upd_tag_full[63:TAG_W]};

  // Lookup reads the registered table, so a same-cycle update is not seen yet.
  assign if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken_o  = start_i && if_hit && ctr_q[if_idx][1];
  assign pred_target_o = pred_taken_o ? target_q[if_idx] : if_pc_i + ADDR_W'(4);

  assign upd_accept   = upd_valid_i && start_i;
  assign upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign mispredict_o = upd_accept && (upd_taken_i != upd_pred_i);

  bp_sat_ctr u_sat_ctr (
    .ctr_i   (ctr_q[upd_idx]),
    .taken_i (upd_taken_i),
    .ctr_o   (upd_ctr_next)
  );

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    ctr_d    = ctr_q;
    target_d = target_q;
    if (clear_i) begin
      valid_d = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) ctr_d[i] = WNT;
    end else if (upd_accept) begin
      if (upd_hit) begin
        ctr_d[upd_idx] = upd_ctr_next;
        if (upd_taken_i) target_d[upd_idx] = upd_target_i;
      end else if (upd_taken_i) begin
        // Taken miss allocates, evicting any alias at this index.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        ctr_d[upd_idx]    = WT;
        target_d[upd_idx] = upd_target_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        ctr_q[i]    <= WNT;
        target_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      ctr_q    <= ctr_d;
      target_q <= target_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mis_q, stat_mis_d;

  // Counters ignore clear_i; only rst_i zeroes them.
  always_comb begin
    stat_br_d  = stat_br_q;
    stat_mis_d = stat_mis_q;
    if (upd_accept && (stat_br_q != '1)) stat_br_d = stat_br_q + 32'd1;
    if (mispredict_o && (stat_mis_q != '1)) stat_mis_d = stat_mis_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_branches_o    = stat_br_q;
  assign stat_mispredicts_o = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed test-plan cases plus a random phase.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst, start, clear;
  logic [31:0] if_pc, upd_pc, upd_target, pred_target;
  logic        upd_valid, upd_taken, upd_pred, pred_taken, mispredict;
`ifdef BP_STATS_EN
  logic [31:0] stat_br, stat_mis;
`endif

  always #5 clk = ~clk;

  branch_predictor #(
    .ENTRIES (16),
    .ADDR_W  (32)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .clear_i       (clear),
    .if_pc_i       (if_pc),
    .pred_taken_o  (pred_taken),
    .pred_target_o (pred_target),
    .upd_valid_i   (upd_valid),
    .upd_pc_i      (upd_pc),
    .upd_taken_i   (upd_taken),
    .upd_target_i  (upd_target),
    .upd_pred_i    (upd_pred),
    .mispredict_o  (mispredict)
`ifdef BP_STATS_EN
    ,
    .stat_branches_o    (stat_br),
    .stat_mispredicts_o (stat_mis)
`endif
  );

  typedef struct {
    logic        tk;
    logic [31:0] tg;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference table: idx = pc[5:2], tag = pc[31:6]
  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  logic [1:0]  m_ctr   [16];
  logic [31:0] m_tgt   [16];
  int unsigned exp_br, exp_mis;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_ctr[i]   = 2'b01;
      m_tgt[i]   = '0;
    end
    exp_br  = 0;
    exp_mis = 0;
  endfunction

  function automatic void model_pred(input logic [31:0] pc, input logic st,
                                     output logic tk, output logic [31:0] tg);
    int unsigned i;
    logic hit;
    i   = 32'(pc[5:2]);
    hit = m_valid[i] && (m_tag[i] == pc[31:6]);
    tk  = st && hit && m_ctr[i][1];
    tg  = tk ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void model_update(input logic uv, input logic [31:0] upc, input logic ut,
                                       input logic [31:0] utg, input logic up, input logic clr,
                                       input logic st);
    int unsigned i;
    logic hit;
    i   = 32'(upc[5:2]);
    hit = m_valid[i] && (m_tag[i] == upc[31:6]);
    if (uv && st) begin
      exp_br++;
      if (ut != up) exp_mis++;
    end
    if (clr) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 2'b01;
      end
    end else if (uv && st) begin
      if (hit) begin
        if (ut) begin
          if (m_ctr[i] != 2'b11) m_ctr[i] = m_ctr[i] + 2'd1;
          m_tgt[i] = utg;
        end else if (m_ctr[i] != 2'b00) begin
          m_ctr[i] = m_ctr[i] - 2'd1;
        end
      end else if (ut) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = upc[31:6];
        m_ctr[i]   = 2'b10;
        m_tgt[i]   = utg;
      end
    end
  endfunction

  // One cycle: drive, push expectation, sample at negedge, then let the edge commit.
  task automatic step(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utg, input logic up, input logic clr,
                      input logic use_model, input logic e_tk, input logic [31:0] e_tg,
                      input logic e_mis);
    exp_t e, got;
    if_pc      = pc;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_taken  = ut;
    upd_target = utg;
    upd_pred   = up;
    clear      = clr;
    if (use_model) begin
      model_pred(pc, start, e.tk, e.tg);
      e.mis = uv && start && (ut != up);
    end else begin
      e.tk  = e_tk;
      e.tg  = e_tg;
      e.mis = e_mis;
    end
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    check_eq("pred_taken", 64'(pred_taken), 64'(got.tk));
    check_eq("pred_target", 64'(pred_target), 64'(got.tg));
    check_eq("mispredict", 64'(mispredict), 64'(got.mis));
    model_update(uv, upc, ut, utg, up, clr, start);
    @(posedge clk);
    #1;
  endtask

  task automatic dir_step(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                          input logic ut, input logic [31:0] utg, input logic up,
                          input logic e_tk, input logic [31:0] e_tg, input logic e_mis);
    step(pc, uv, upc, ut, utg, up, 1'b0, 1'b0, e_tk, e_tg, e_mis);
  endtask

  task automatic do_reset(input logic [31:0] pc);
    rst = 1'b1; start = 1'b1; clear = 1'b0; if_pc = pc;
    upd_valid = 1'b0; upd_taken = 1'b0; upd_pred = 1'b0; upd_pc = '0; upd_target = '0;
    #2;
    check_eq("rst_taken", 64'(pred_taken), 64'd0);
    check_eq("rst_target", 64'(pred_target), 64'(pc + 32'd4));
    check_eq("rst_mis", 64'(mispredict), 64'd0);
`ifdef BP_STATS_EN
    check_eq("rst_stat_br", 64'(stat_br), 64'd0);
    check_eq("rst_stat_mis", 64'(stat_mis), 64'd0);
`endif
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pcs [8];
    pcs = '{32'h40, 32'h80, 32'hC0, 32'h44, 32'h48, 32'h100, 32'h1040, 32'h3C};

    do_reset(32'h40);
    // Cold lookup, then taken-miss allocate; same-cycle lookup sees old contents
    dir_step(32'h40, 0, 0, 0, 0, 0, 1'b0, 32'h44, 1'b0);
    dir_step(32'h40, 1, 32'h40, 1, 32'h10, 0, 1'b0, 32'h44, 1'b1);
    dir_step(32'h40, 0, 0, 0, 0, 0, 1'b1, 32'h10, 1'b0);
    // Hysteresis: WT -> ST -> WT -> WNT
    dir_step(32'h40, 1, 32'h40, 1, 32'h10, 1, 1'b1, 32'h10, 1'b0);
    dir_step(32'h40, 1, 32'h40, 0, 32'h0, 1, 1'b1, 32'h10, 1'b1);
    dir_step(32'h40, 1, 32'h40, 0, 32'h0, 1, 1'b1, 32'h10, 1'b1);
    dir_step(32'h40, 0, 0, 0, 0, 0, 1'b0, 32'h44, 1'b0);
    // Alias replacement at index 0
    dir_step(32'h80, 1, 32'h40, 1, 32'h10, 0, 1'b0, 32'h84, 1'b1);
    dir_step(32'h40, 1, 32'h80, 1, 32'h200, 0, 1'b1, 32'h10, 1'b1);
    dir_step(32'h80, 0, 0, 0, 0, 0, 1'b1, 32'h200, 1'b0);
    dir_step(32'h40, 0, 0, 0, 0, 0, 1'b0, 32'h44, 1'b0);
    // start_i low forces not-taken and blocks updates
    start = 1'b0;
    dir_step(32'h80, 1, 32'h80, 0, 32'h0, 1, 1'b0, 32'h84, 1'b0);
    start = 1'b1;
    dir_step(32'h80, 0, 0, 0, 0, 0, 1'b1, 32'h200, 1'b0);
    // Fall-through wraps modulo 2^32
    dir_step(32'hFFFF_FFFC, 0, 0, 0, 0, 0, 1'b0, 32'h0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      start = ($urandom_range(0, 7) != 0);
      step(pcs[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), pcs[$urandom_range(0, 7)],
           1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)) << 2,
           1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0), 1'b1, 1'b0, 32'h0, 1'b0);
    end
    start = 1'b1;
`ifdef BP_STATS_EN
    check_eq("rand_stat_br", 64'(stat_br), 64'(exp_br));
    check_eq("rand_stat_mis", 64'(stat_mis), 64'(exp_mis));
`endif

    // Train 0x80 then assert reset mid-operation
    step(32'h0, 1, 32'h80, 1, 32'h200, 0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(32'h0, 1, 32'h80, 1, 32'h200, 0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    dir_step(32'h80, 0, 0, 0, 0, 0, 1'b1, 32'h200, 1'b0);
    do_reset(32'h80);

    // Three updates, one mispredict
    dir_step(32'h300, 1, 32'h100, 1, 32'h500, 0, 1'b0, 32'h304, 1'b1);
    dir_step(32'h300, 1, 32'h100, 1, 32'h500, 1, 1'b0, 32'h304, 1'b0);
    dir_step(32'h300, 1, 32'h104, 0, 32'h0, 0, 1'b0, 32'h304, 1'b0);
    dir_step(32'h100, 0, 0, 0, 0, 0, 1'b1, 32'h500, 1'b0);
`ifdef BP_STATS_EN
    check_eq("stat_br_3", 64'(stat_br), 64'd3);
    check_eq("stat_mis_1", 64'(stat_mis), 64'd1);
`endif
    // clear_i invalidates; counters keep their values
    step(32'h100, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0);
    dir_step(32'h100, 0, 0, 0, 0, 0, 1'b0, 32'h104, 1'b0);
`ifdef BP_STATS_EN
    check_eq("clr_stat_br", 64'(stat_br), 64'd3);
    check_eq("clr_stat_mis", 64'(stat_mis), 64'd1);
`endif
    // clear_i wins over a same-cycle taken update
    step(32'h300, 1, 32'h40, 1, 32'h20, 1, 1'b1, 1'b0, 1'b0, 32'h304, 1'b0);
    dir_step(32'h40, 0, 0, 0, 0, 0, 1'b0, 32'h44, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
